// File: rtl/wb_bus_guard.sv
// Registered Wishbone slice between the management master and the user-area
// peripherals, with a watchdog that force-completes cycles a peripheral never acks.
module wb_bus_guard #(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [31:0] TO_DATA = 32'hDEADBEEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    input  logic        irq_clr_i,
    output logic        timeout_irq,
    output logic [7:0]  timeout_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Wait counter value seen in the last REQ cycle before a forced completion.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 32'd1);

    state_t      state_r;
    state_t      next_state_s;
    logic [15:0] wait_cnt_r;
    logic        take_s;
    logic        ack_s;
    logic        timeout_s;

    // Next-state decode; in REQ the priority is abort, then ack, then timeout.
    always_comb begin
        next_state_s = state_r;
        take_s       = 1'b0;
        ack_s        = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    take_s       = 1'b1;
                    next_state_s = REQ;
                end else begin
                    next_state_s = IDLE;
                end
            end
            REQ: begin
                if (!wbs_cyc_i) begin
                    next_state_s = IDLE;
                end else if (wbm_ack_i) begin
                    ack_s        = 1'b1;
                    next_state_s = RESP;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    timeout_s    = 1'b1;
                    next_state_s = RESP;
                end else begin
                    next_state_s = REQ;
                end
            end
            RESP: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Wait counter runs only while staying in REQ; any other path restarts it.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wait_cnt_r <= 16'd0;
        end else if ((state_r == REQ) && (next_state_s == REQ)) begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
        end else begin
            wait_cnt_r <= 16'd0;
        end
    end

    // Downstream request registers; address/data/select/we hold between captures.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_adr_o <= 32'h0000_0000;
            wbm_dat_o <= 32'h0000_0000;
        end else begin
            wbm_cyc_o <= (next_state_s == REQ);
            wbm_stb_o <= (next_state_s == REQ);
            if (take_s) begin
                wbm_we_o  <= wbs_we_i;
                wbm_sel_o <= wbs_sel_i;
                wbm_adr_o <= wbs_adr_i;
                wbm_dat_o <= wbs_dat_i;
            end
        end
    end

    // Upstream response; ack is a single-cycle pulse in RESP, data holds otherwise.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0000_0000;
        end else begin
            wbs_ack_o <= (next_state_s == RESP);
            if (ack_s) begin
                wbs_dat_o <= wbm_dat_i;
            end else if (timeout_s) begin
                wbs_dat_o <= TO_DATA;
            end
        end
    end

    // Sticky irq (a new timeout beats a simultaneous clear) and saturating count.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            timeout_irq <= 1'b0;
            timeout_cnt <= 8'd0;
        end else begin
            if (timeout_s) begin
                timeout_irq <= 1'b1;
            end else if (irq_clr_i) begin
                timeout_irq <= 1'b0;
            end
            if (timeout_s && (timeout_cnt != 8'hFF)) begin
                timeout_cnt <= timeout_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_bus_guard.sv
// Directed bench for wb_bus_guard (TIMEOUT=4): normal reads/writes, timeouts,
// irq set/clear, counter saturation, abort and asynchronous reset.
module tb_wb_bus_guard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = 32'h0;
    logic [31:0] wbs_dat_i = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i = 1'b0;
    logic [31:0] wbm_dat_i = 32'h0;
    logic        irq_clr_i = 1'b0;
    logic        timeout_irq;
    logic [7:0]  timeout_cnt;

    int n_checks = 0;
    int n_fail = 0;

    wb_bus_guard #(.TIMEOUT(4), .TO_DATA(32'hDEADBEEF)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_ack_i  (wbm_ack_i),
        .wbm_dat_i  (wbm_dat_i),
        .irq_clr_i  (irq_clr_i),
        .timeout_irq(timeout_irq),
        .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to 1 time unit after the next rising edge (i.e. into the next cycle).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, {31'd0, wbs_ack_o}, 32'd0);
        check({tag, "_sdat"}, wbs_dat_o, 32'd0);
        check({tag, "_mcyc"}, {31'd0, wbm_cyc_o}, 32'd0);
        check({tag, "_mstb"}, {31'd0, wbm_stb_o}, 32'd0);
        check({tag, "_mwe"}, {31'd0, wbm_we_o}, 32'd0);
        check({tag, "_msel"}, {28'd0, wbm_sel_o}, 32'd0);
        check({tag, "_madr"}, wbm_adr_o, 32'd0);
        check({tag, "_mdat"}, wbm_dat_o, 32'd0);
        check({tag, "_irq"}, {31'd0, timeout_irq}, 32'd0);
        check({tag, "_cnt"}, {24'd0, timeout_cnt}, 32'd0);
    endtask

    task automatic start(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = 4'hF;
    endtask

    task automatic stop();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbm_ack_i = 1'b0;
    endtask

    initial begin
        logic got;
        // Reset state
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;

        // Read with 0-wait peripheral, strobe issued right after reset release
        start(1'b0, 32'h3000_0000, 32'h0);
        step();                                   // cycle 1
        check("rd_stb_c1", {31'd0, wbm_stb_o}, 32'd1);
        check("rd_cyc_c1", {31'd0, wbm_cyc_o}, 32'd1);
        check("rd_adr_c1", wbm_adr_o, 32'h3000_0000);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h1234_5678;
        step();                                   // cycle 2
        check("rd_ack_c2", {31'd0, wbs_ack_o}, 32'd1);
        check("rd_dat_c2", wbs_dat_o, 32'h1234_5678);
        check("rd_irq_c2", {31'd0, timeout_irq}, 32'd0);
        check("rd_stb_c2", {31'd0, wbm_stb_o}, 32'd0);
        stop();
        step();                                   // cycle 3
        check("rd_ack_c3", {31'd0, wbs_ack_o}, 32'd0);
        check("rd_dat_hold", wbs_dat_o, 32'h1234_5678);

        // Write with 3-wait peripheral (acks in REQ cycle 4)
        start(1'b1, 32'h3002_0004, 32'h0000_00A5);
        step();
        for (int i = 1; i <= 4; i++) begin
            check("wr_stb", {31'd0, wbm_stb_o}, 32'd1);
            check("wr_we", {31'd0, wbm_we_o}, 32'd1);
            check("wr_adr", wbm_adr_o, 32'h3002_0004);
            check("wr_dat", wbm_dat_o, 32'h0000_00A5);
            check("wr_sel", {28'd0, wbm_sel_o}, 32'hF);
            check("wr_noack", {31'd0, wbs_ack_o}, 32'd0);
            if (i == 4) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = 32'h0000_0055;
            end
            step();
        end
        check("wr_ack_c5", {31'd0, wbs_ack_o}, 32'd1);
        check("wr_stb_c5", {31'd0, wbm_stb_o}, 32'd0);
        check("wr_lastack_dat", wbs_dat_o, 32'h0000_0055);
        check("wr_lastack_irq", {31'd0, timeout_irq}, 32'd0);
        check("wr_lastack_cnt", {24'd0, timeout_cnt}, 32'd0);
        stop();
        step();
        check("wr_adr_hold", wbm_adr_o, 32'h3002_0004);

        // Timeout, no downstream ack; strobe left high through RESP
        start(1'b0, 32'h3003_0000, 32'h0);
        step();
        for (int i = 1; i <= 4; i++) begin
            check("to_stb", {31'd0, wbm_stb_o}, 32'd1);
            check("to_noack", {31'd0, wbs_ack_o}, 32'd0);
            step();
        end
        check("to_ack_c5", {31'd0, wbs_ack_o}, 32'd1);
        check("to_dat_c5", wbs_dat_o, 32'hDEADBEEF);
        check("to_irq_c5", {31'd0, timeout_irq}, 32'd1);
        check("to_cnt_c5", {24'd0, timeout_cnt}, 32'd1);
        check("to_stb_c5", {31'd0, wbm_stb_o}, 32'd0);
        step();                                   // cycle 6: RESP strobe not re-accepted
        check("to_noreaccept", {31'd0, wbm_stb_o}, 32'd0);
        check("to_ack_c6", {31'd0, wbs_ack_o}, 32'd0);
        stop();

        // Clear alone
        irq_clr_i = 1'b1;
        step();
        irq_clr_i = 1'b0;
        check("clr_irq", {31'd0, timeout_irq}, 32'd0);
        check("clr_cnt", {24'd0, timeout_cnt}, 32'd1);

        // Ack on the final timeout cycle
        start(1'b0, 32'h3004_0000, 32'h0);
        step();
        step();
        step();
        step();                                   // cycle 4
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h0000_0055;
        step();                                   // cycle 5
        check("last_ack", {31'd0, wbs_ack_o}, 32'd1);
        check("last_dat", wbs_dat_o, 32'h0000_0055);
        check("last_irq", {31'd0, timeout_irq}, 32'd0);
        check("last_cnt", {24'd0, timeout_cnt}, 32'd1);
        stop();
        step();

        // Set and clear in the same cycle as a timeout: set wins
        start(1'b0, 32'h3005_0000, 32'h0);
        step();
        step();
        step();
        step();                                   // cycle 4: timeout edge ahead
        irq_clr_i = 1'b1;
        step();                                   // cycle 5
        irq_clr_i = 1'b0;
        check("setclr_irq", {31'd0, timeout_irq}, 32'd1);
        check("setclr_cnt", {24'd0, timeout_cnt}, 32'd2);
        check("setclr_dat", wbs_dat_o, 32'hDEADBEEF);
        stop();
        step();

        // Abort: cyc drops in REQ cycle 2
        start(1'b0, 32'h3006_0000, 32'h0);
        step();                                   // cycle 1
        check("ab_stb_c1", {31'd0, wbm_stb_o}, 32'd1);
        step();                                   // cycle 2
        stop();
        step();                                   // cycle 3
        check("ab_cyc_c3", {31'd0, wbm_cyc_o}, 32'd0);
        check("ab_stb_c3", {31'd0, wbm_stb_o}, 32'd0);
        check("ab_ack_c3", {31'd0, wbs_ack_o}, 32'd0);
        step();
        check("ab_ack_c4", {31'd0, wbs_ack_o}, 32'd0);
        check("ab_cnt", {24'd0, timeout_cnt}, 32'd2);
        check("ab_dat", wbs_dat_o, 32'hDEADBEEF);

        // Asynchronous reset mid-REQ, then a strobe straight after release
        start(1'b0, 32'h3007_0000, 32'h0);
        step();
        step();                                   // cycle 2 of REQ
        rst = 1'b1;
        #1;
        check_all_zero("arst");
        step();
        rst = 1'b0;
        step();                                   // cycle 1 after strobe accepted
        check("post_rst_stb", {31'd0, wbm_stb_o}, 32'd1);
        check("post_rst_adr", wbm_adr_o, 32'h3007_0000);
        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'hCAFE_0001;
        step();
        check("post_rst_ack", {31'd0, wbs_ack_o}, 32'd1);
        check("post_rst_dat", wbs_dat_o, 32'hCAFE_0001);
        stop();
        step();

        // Saturation: 300 timeouts from a freshly reset counter
        for (int n = 1; n <= 300; n++) begin
            start(1'b0, 32'h3008_0000, 32'h0);
            got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                step();
                if (wbs_ack_o) got = 1'b1;
            end
            check("sat_ack_seen", {31'd0, got}, 32'd1);
            stop();
            step();
            if (n == 200) check("sat_cnt_200", {24'd0, timeout_cnt}, 32'd200);
        end
        check("sat_cnt_300", {24'd0, timeout_cnt}, 32'd255);
        check("sat_irq", {31'd0, timeout_irq}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
